// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the configurable UART.
// Used by the transmitter now and the receiver later.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_e;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    localparam int MIN_DIV = 3;

    function automatic logic [3:0] bits_from_cfg(input logic [1:0] cfg);
        return 4'd5 + {2'b00, cfg};
    endfunction

    function automatic logic [7:0] word_mask(input logic [1:0] cfg);
        return 8'hFF >> (2'd3 - cfg);
    endfunction

endpackage

// File: rtl/uart_tx_cfg_fifo.sv
// sync_fifo: single-clock FIFO, head word visible on rd_data_o.
// Pointers carry an extra wrap bit to tell full from empty.
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     rd_en_i,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             wr, rd;

    assign full_o  = (wptr_q[AW] != rptr_q[AW]) &&
                     (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty_o = (wptr_q == rptr_q);
    assign level_o = wptr_q - rptr_q;
    assign rd_data_o = mem_q[rptr_q[AW-1:0]];

    assign wr = wr_en_i && !full_o;
    assign rd = rd_en_i && !empty_o;

    always_comb begin
        wptr_d = wptr_q + {{AW{1'b0}}, wr};
        rptr_d = rptr_q + {{AW{1'b0}}, rd};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr) mem_q[wptr_q[AW-1:0]] <= wr_data_i;
    end

endmodule

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: UART transmitter with input FIFO and runtime framing.
// Frame settings are latched when a byte leaves the FIFO.
module uart_tx_cfg #(
    parameter int CLOCK_FREQ = 50000000,
    parameter int BAUD       = 115200,
    parameter int DIV_W      = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [7:0]                    s_data,
    input  logic [DIV_W-1:0]              cfg_div,
    input  logic [1:0]                    cfg_bits,
    input  logic [1:0]                    cfg_parity,
    input  logic                          cfg_stop2,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    import uart_pkg::*;

    localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(CLOCK_FREQ / BAUD);
    localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);
    localparam logic [DIV_W-1:0] MIN_D   = DIV_W'(MIN_DIV);

    state_e           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d, div_q, div_d, eff_div;
    logic [7:0]       sh_q, sh_d, f_data, word;
    logic [2:0]       bit_q, bit_d;
    logic             pen_q, pen_d, pbit_q, pbit_d;
    logic             s2_q, s2_d, stop_q, stop_d, tx_q, tx_d;
    logic             pop, f_full, f_empty, tick;
    logic             par_x, pen_c, pbit_c;

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (s_valid),
        .wr_data_i (s_data),
        .rd_en_i   (pop),
        .rd_data_o (f_data),
        .full_o    (f_full),
        .empty_o   (f_empty),
        .level_o   (fifo_level)
    );

    assign s_ready = !f_full;
    assign tx      = tx_q;
    assign busy    = (state_q != IDLE) || (fifo_level != '0);
    assign tick    = (cnt_q == '0);

    always_comb begin
        if (cfg_div == '0)      eff_div = DEF_DIV;
        else if (cfg_div < MIN_D) eff_div = MIN_D;
        else                    eff_div = cfg_div;
    end

    always_comb begin
        word   = f_data & word_mask(cfg_bits);
        par_x  = ^word;
        pen_c  = 1'b0;
        pbit_c = 1'b0;
        unique case (cfg_parity)
            PAR_EVEN: begin pen_c = 1'b1; pbit_c = par_x;  end
            PAR_ODD:  begin pen_c = 1'b1; pbit_c = ~par_x; end
            PAR_NONE, 2'b11: pen_c = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        sh_d    = sh_q;
        bit_d   = bit_q;
        pen_d   = pen_q;
        pbit_d  = pbit_q;
        s2_d    = s2_q;
        stop_d  = stop_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        if (state_q != IDLE) cnt_d = tick ? div_q - ONE : cnt_q - ONE;
        unique case (state_q)
            IDLE: pop = !f_empty;
            START: if (tick) begin
                state_d = DATA;
                tx_d    = sh_q[0];
                sh_d    = sh_q >> 1;
            end
            DATA: if (tick) begin
                if (bit_q != 3'd0) begin
                    tx_d  = sh_q[0];
                    sh_d  = sh_q >> 1;
                    bit_d = bit_q - 3'd1;
                end else if (pen_q) begin
                    state_d = PARITY;
                    tx_d    = pbit_q;
                end else begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                    stop_d  = s2_q;
                end
            end
            PARITY: if (tick) begin
                state_d = STOP;
                tx_d    = 1'b1;
                stop_d  = s2_q;
            end
            STOP: if (tick) begin
                if (stop_q)        stop_d  = 1'b0;
                else if (!f_empty) pop     = 1'b1;
                else               state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // a pop always starts a new frame, from IDLE or the last stop bit
        if (pop) begin
            state_d = START;
            tx_d    = 1'b0;
            cnt_d   = eff_div - ONE;
            div_d   = eff_div;
            sh_d    = word;
            bit_d   = 3'(bits_from_cfg(cfg_bits) - 4'd1);
            pen_d   = pen_c;
            pbit_d  = pbit_c;
            s2_d    = cfg_stop2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            div_q   <= '0;
            sh_q    <= '0;
            bit_q   <= '0;
            pen_q   <= 1'b0;
            pbit_q  <= 1'b0;
            s2_q    <= 1'b0;
            stop_q  <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            sh_q    <= sh_d;
            bit_q   <= bit_d;
            pen_q   <= pen_d;
            pbit_q  <= pbit_d;
            s2_q    <= s2_d;
            stop_q  <= stop_d;
            tx_q    <= tx_d;
        end
    end

endmodule
